// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS-232 receive and transmit blocks.
package rs232_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } rx_state_e;

    localparam int OVERSAMPLE = 16;

    // rate is the tick rate divided by Hz granularity: Baud*16 for the receiver, Baud for a 1x transmitter.
    function automatic longint baud_inc(input longint clk_freq, input longint rate, input int acc_width);
        return ((rate << (acc_width - 7)) + (clk_freq >> 8)) / (clk_freq >> 7);
    endfunction

endpackage

// File: rtl/rs232_baud_tick_gen.sv
// Fractional baud tick generator: the accumulator carry is the tick, at roughly Baud*Oversampling Hz.
module rs232_baud_tick_gen
    import rs232_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 1,
    parameter int AccWidth     = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam longint INC_L = baud_inc(longint'(ClkFrequency), longint'(Baud) * Oversampling, AccWidth);
    localparam logic [AccWidth:0] INC = INC_L[AccWidth:0];

    logic [AccWidth:0] acc_q, acc_d;

    always_comb begin
        acc_d = {1'b0, acc_q[AccWidth-1:0]} + INC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign tick = acc_q[AccWidth];

endmodule

// File: rtl/async_receiver_os16.sv
// 8N1 serial receiver with 16x oversampling, 3-sample majority vote, one-deep holding register and idle detection.
//   IDLE   | line high, waiting for a start edge      START | validating start bit at mid-bit
//   DATA   | sampling 8 data bits, LSB first         STOP  | checking stop bit, delivering byte
//   WAITHI | after a framing error, wait for line high before re-arming
module async_receiver_os16
    import rs232_pkg::*;
#(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 16,
    parameter int AccWidth     = 16,
    parameter int IdleBits     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_valid,
    input  logic       RxD_ack,
    output logic       RxD_frame_err,
    output logic       RxD_overrun,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
);

    localparam int IDLE_TICKS = IdleBits * OVERSAMPLE;
    localparam int ICW = $clog2(IDLE_TICKS + 1);
    localparam logic [ICW-1:0] IDLE_MAX = ICW'(IDLE_TICKS);

    logic tick;

    rs232_baud_tick_gen #(
        .ClkFrequency(ClkFrequency),
        .Baud        (Baud),
        .Oversampling(Oversampling),
        .AccWidth    (AccWidth)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    logic [1:0]     sync_q, sync_d;
    rx_state_e      state_q, state_d;
    logic [3:0]     tc_q, tc_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           s7_q, s7_d, s8_q, s8_d;
    logic           deliver_q, deliver_d;
    logic           frame_err_q, frame_err_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;
    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic           idle_prev_q, idle_prev_d;
    logic           eop_pend_q, eop_pend_d;

    logic rxd_s, maj, decide, idle, eop, overrun_evt;

    assign rxd_s  = sync_q[1];
    assign maj    = (s7_q & s8_q) | (s7_q & rxd_s) | (s8_q & rxd_s);
    assign decide = tick && (tc_q == 4'd9);

    always_comb begin
        sync_d      = {sync_q[0], RxD};
        state_d     = state_q;
        tc_d        = tc_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        s7_d        = s7_q;
        s8_d        = s8_q;
        deliver_d   = 1'b0;
        frame_err_d = 1'b0;

        if (tick && state_q != IDLE) begin
            tc_d = tc_q + 4'd1;
            if (tc_q == 4'd7) s7_d = rxd_s;
            if (tc_q == 4'd8) s8_d = rxd_s;
        end

        case (state_q)
            IDLE: begin
                if (tick && !rxd_s) begin
                    state_d = START;
                    tc_d    = 4'd0;
                end
            end
            START: begin
                if (decide) begin
                    state_d = maj ? IDLE : DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d[idx_q] = maj;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                // Leave mid-stop-bit so an immediately following start edge is not missed.
                if (decide) begin
                    state_d     = maj ? IDLE : WAITHI;
                    deliver_d   = maj;
                    frame_err_d = ~maj;
                end
            end
            WAITHI: begin
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        overrun_evt = deliver_q && valid_q && !RxD_ack;

        if (deliver_q) begin
            if (!valid_q || RxD_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (RxD_ack && valid_q) begin
            valid_d = 1'b0;
        end

        if (RxD_ack && !overrun_evt) overrun_d = 1'b0;
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (state_q != IDLE || !rxd_s)
            idle_cnt_d = '0;
        else if (tick && idle_cnt_q != IDLE_MAX)
            idle_cnt_d = idle_cnt_q + ICW'(1);

        idle        = (idle_cnt_q == IDLE_MAX);
        idle_prev_d = idle;
        eop         = idle && !idle_prev_q && eop_pend_q;

        eop_pend_d = eop_pend_q;
        if (deliver_q) eop_pend_d = 1'b1;
        else if (eop)  eop_pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            tc_q        <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            s7_q        <= 1'b1;
            s8_q        <= 1'b1;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            idle_cnt_q  <= '0;
            idle_prev_q <= 1'b0;
            eop_pend_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            tc_q        <= tc_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            deliver_q   <= deliver_d;
            frame_err_q <= frame_err_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            idle_cnt_q  <= idle_cnt_d;
            idle_prev_q <= idle_prev_d;
            eop_pend_q  <= eop_pend_d;
        end
    end

    assign RxD_data        = data_q;
    assign RxD_data_valid  = valid_q;
    assign RxD_frame_err   = frame_err_q;
    assign RxD_overrun     = overrun_q;
    assign RxD_idle        = idle;
    assign RxD_endofpacket = eop;

endmodule
